// File: rtl/fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// fetch_decode_unit
//
// Front end of the RV32I multi-cycle processor. It holds the program counter
// and the instruction register, splits the latched instruction into its
// fields, builds the sign-extended immediate, evaluates the conditional-branch
// condition and selects the next PC. There is no internal sequencing. The
// external controller decides when to load the IR and when to update the PC.
//
// Ports:
//   clk                 system clock, all state changes on the rising edge
//   rst_n               synchronous active-low reset
//   read_data           instruction word from the memory read port
//   ir_write            load read_data into the IR (and pc into pc_instr)
//   pc_write            load the selected next PC into pc
//   select_pc_value     1: next PC is the jump target from alu_output
//   alu_output          jal/jalr jump target computed by the ALU
//   rs1v, rs2v          register operands for the branch comparison
//   pc                  current fetch address
//   pc_instr            address of the instruction held in the IR
//   current_instruction latched instruction word
//   opcode .. funct7    decoded instruction fields
//   immediate_value     decoded, sign-extended immediate
//   branch_taken        branch condition for the instruction in the IR
// ---------------------------------------------------------------------------
module fetch_decode_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_data,
  input  logic        ir_write,
  input  logic        pc_write,
  input  logic        select_pc_value,
  input  logic [31:0] alu_output,
  input  logic [31:0] rs1v,
  input  logic [31:0] rs2v,
  output logic [31:0] pc,
  output logic [31:0] pc_instr,
  output logic [31:0] current_instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic [31:0] immediate_value,
  output logic        branch_taken
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] next_pc;

  // Field extraction is pure wiring, so the fields follow the IR in the same
  // cycle that it is loaded.
  assign opcode = current_instruction[6:0];
  assign rd     = current_instruction[11:7];
  assign funct3 = current_instruction[14:12];
  assign rs1    = current_instruction[19:15];
  assign rs2    = current_instruction[24:20];
  assign funct7 = current_instruction[31:25];

  // Immediate generator. B and J immediates are byte offsets with an
  // implicit zero LSB. Opcodes without an immediate (R-type, fence, system)
  // produce zero.
  always_comb begin
    immediate_value = 32'h0;
    unique case (opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        immediate_value = {{20{current_instruction[31]}}, current_instruction[31:20]};
      OP_STORE:
        immediate_value = {{20{current_instruction[31]}}, current_instruction[31:25],
                           current_instruction[11:7]};
      OP_BRANCH:
        immediate_value = {{19{current_instruction[31]}}, current_instruction[31],
                           current_instruction[7], current_instruction[30:25],
                           current_instruction[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        immediate_value = {current_instruction[31:12], 12'h000};
      OP_JAL:
        immediate_value = {{11{current_instruction[31]}}, current_instruction[31],
                           current_instruction[19:12], current_instruction[20],
                           current_instruction[30:21], 1'b0};
      default:
        immediate_value = 32'h0;
    endcase
  end

  // Branch condition. The reserved funct3 encodings 010 and 011 are never
  // taken, so a malformed branch falls through to pc + 4.
  always_comb begin
    branch_taken = 1'b0;
    if (opcode == OP_BRANCH) begin
      unique case (funct3)
        3'b000:  branch_taken = (rs1v == rs2v);
        3'b001:  branch_taken = (rs1v != rs2v);
        3'b100:  branch_taken = ($signed(rs1v) <  $signed(rs2v));
        3'b101:  branch_taken = ($signed(rs1v) >= $signed(rs2v));
        3'b110:  branch_taken = (rs1v <  rs2v);
        3'b111:  branch_taken = (rs1v >= rs2v);
        default: branch_taken = 1'b0;
      endcase
    end
  end

  // Next-PC selection. A jump target wins over a taken branch. The branch
  // target is relative to the instruction's own address (pc_instr), not to
  // the fetch PC, which may already have advanced. Bit 0 of jump targets is
  // cleared as jalr requires. Other misalignment passes through untouched.
  always_comb begin
    next_pc = pc + 32'd4;
    if (select_pc_value)
      next_pc = {alu_output[31:1], 1'b0};
    else if (branch_taken)
      next_pc = pc_instr + immediate_value;
  end

  // State registers. With ir_write and pc_write high together, pc_instr takes
  // the pre-edge pc and next_pc is built from the pre-edge IR.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc                  <= RESET_PC;
      pc_instr            <= RESET_PC;
      current_instruction <= NOP_INSN;
    end else begin
      if (ir_write) begin
        current_instruction <= read_data;
        pc_instr            <= pc;
      end
      if (pc_write)
        pc <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_unit
//
// Self-checking bench for fetch_decode_unit. A decode table covers the
// immediate formats and field extraction. A branch table covers every funct3
// condition. Hand-written sequences cover reset, fetch, PC update,
// simultaneous IR/PC writes, jumps, hold and PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_data;
  logic        ir_write;
  logic        pc_write;
  logic        select_pc_value;
  logic [31:0] alu_output;
  logic [31:0] rs1v;
  logic [31:0] rs2v;
  logic [31:0] pc;
  logic [31:0] pc_instr;
  logic [31:0] current_instruction;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] immediate_value;
  logic        branch_taken;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_decode_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .read_data           (read_data),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .select_pc_value     (select_pc_value),
    .alu_output          (alu_output),
    .rs1v                (rs1v),
    .rs2v                (rs2v),
    .pc                  (pc),
    .pc_instr            (pc_instr),
    .current_instruction (current_instruction),
    .opcode              (opcode),
    .rd                  (rd),
    .funct3              (funct3),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .funct7              (funct7),
    .immediate_value     (immediate_value),
    .branch_taken        (branch_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic [6:0]  exp_opcode;
    logic [4:0]  exp_rd;
    logic [2:0]  exp_funct3;
    logic [4:0]  exp_rs1;
    logic [4:0]  exp_rs2;
    logic [6:0]  exp_funct7;
    logic [31:0] exp_imm;
  } dec_vec_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_taken;
  } br_vec_t;

  dec_vec_t dec_vec [10];
  br_vec_t  br_vec  [15];

  // Drive one cycle of control inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic        rstn_i,
                               input logic        irw_i,
                               input logic        pcw_i,
                               input logic        sel_i,
                               input logic [31:0] rdata_i,
                               input logic [31:0] alu_i);
    rst_n           = rstn_i;
    ir_write        = irw_i;
    pc_write        = pcw_i;
    select_pc_value = sel_i;
    read_data       = rdata_i;
    alu_output      = alu_i;
    @(posedge clk);
    #1;
    ir_write = 1'b0;
    pc_write = 1'b0;
  endtask

  task automatic checkOutput(input string name,
                             input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  initial begin
    // Decode table: instruction, opcode, rd, funct3, rs1, rs2, funct7, imm
    dec_vec[0] = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 5'd0,  5'd31, 7'h7F, 32'hFFFFFFFF}; // addi x1,x0,-1
    dec_vec[1] = '{32'h00112423, 7'h23, 5'd8,  3'd2, 5'd2,  5'd1,  7'h00, 32'h00000008}; // sw x1,8(x2)
    dec_vec[2] = '{32'hFE112E23, 7'h23, 5'd28, 3'd2, 5'd2,  5'd1,  7'h7F, 32'hFFFFFFFC}; // sw x1,-4(x2)
    dec_vec[3] = '{32'hFE000EE3, 7'h63, 5'd29, 3'd0, 5'd0,  5'd0,  7'h7F, 32'hFFFFFFFC}; // beq -4
    dec_vec[4] = '{32'h123450B7, 7'h37, 5'd1,  3'd5, 5'd8,  5'd3,  7'h09, 32'h12345000}; // lui
    dec_vec[5] = '{32'h0080006F, 7'h6F, 5'd0,  3'd0, 5'd0,  5'd8,  7'h00, 32'h00000008}; // jal +8
    dec_vec[6] = '{32'hFFDFF06F, 7'h6F, 5'd0,  3'd7, 5'd31, 5'd29, 7'h7F, 32'hFFFFFFFC}; // jal -4
    dec_vec[7] = '{32'h002081B3, 7'h33, 5'd3,  3'd0, 5'd1,  5'd2,  7'h00, 32'h00000000}; // add
    dec_vec[8] = '{32'h80002103, 7'h03, 5'd2,  3'd2, 5'd0,  5'd0,  7'h40, 32'hFFFFF800}; // lw -2048
    dec_vec[9] = '{32'h0000000F, 7'h0F, 5'd0,  3'd0, 5'd0,  5'd0,  7'h00, 32'h00000000}; // fence

    // Branch table: instruction, rs1v, rs2v, expected branch_taken
    br_vec[0]  = '{32'hFE000EE3, 32'd5,        32'd5,        1'b1}; // beq equal
    br_vec[1]  = '{32'hFE000EE3, 32'd5,        32'd6,        1'b0}; // beq differ
    br_vec[2]  = '{32'hFE001EE3, 32'd5,        32'd6,        1'b1}; // bne differ
    br_vec[3]  = '{32'hFE001EE3, 32'd7,        32'd7,        1'b0}; // bne equal
    br_vec[4]  = '{32'hFE002EE3, 32'd5,        32'd5,        1'b0}; // funct3 010
    br_vec[5]  = '{32'hFE003EE3, 32'd5,        32'd5,        1'b0}; // funct3 011
    br_vec[6]  = '{32'hFE004EE3, 32'hFFFFFFFF, 32'd1,        1'b1}; // blt -1<1
    br_vec[7]  = '{32'hFE004EE3, 32'd1,        32'hFFFFFFFF, 1'b0}; // blt 1<-1
    br_vec[8]  = '{32'hFE005EE3, 32'hFFFFFFFF, 32'd1,        1'b0}; // bge -1>=1
    br_vec[9]  = '{32'hFE005EE3, 32'd3,        32'd3,        1'b1}; // bge equal
    br_vec[10] = '{32'hFE006EE3, 32'hFFFFFFFF, 32'd1,        1'b0}; // bltu
    br_vec[11] = '{32'hFE006EE3, 32'd1,        32'hFFFFFFFF, 1'b1}; // bltu
    br_vec[12] = '{32'hFE007EE3, 32'hFFFFFFFF, 32'd1,        1'b1}; // bgeu
    br_vec[13] = '{32'hFE007EE3, 32'd0,        32'd1,        1'b0}; // bgeu
    br_vec[14] = '{32'h002081B3, 32'd5,        32'd5,        1'b0}; // add is not a branch

    rs1v = 32'd0;
    rs2v = 32'd0;

    // Reset overrides ir_write/pc_write.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000100);
    checkOutput("reset_pc",       pc,                  32'h0);
    checkOutput("reset_pc_instr", pc_instr,            32'h0);
    checkOutput("reset_ir",       current_instruction, 32'h00000013);
    checkOutput("reset_opcode",   {25'b0, opcode},     32'h13);
    checkOutput("reset_imm",      immediate_value,     32'h0);
    checkOutput("reset_taken",    {31'b0, branch_taken}, 32'h0);

    // Fetch addi, then advance PC.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFF00093, 32'h0);
    checkOutput("fetch_ir",       current_instruction, 32'hFFF00093);
    checkOutput("fetch_pc_hold",  pc,                  32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h0);
    checkOutput("fetch_rd",       {27'b0, rd},         32'd1);
    checkOutput("fetch_rs1",      {27'b0, rs1},        32'd0);
    checkOutput("fetch_funct3",   {29'b0, funct3},     32'd0);
    checkOutput("fetch_imm",      immediate_value,     32'hFFFFFFFF);
    checkOutput("fetch_pc",       pc,                  32'h4);
    checkOutput("fetch_pc_instr", pc_instr,            32'h0);
    checkOutput("ir_hold",        current_instruction, 32'hFFF00093);

    // Advance to pc=0x10, then load beq with pc_write at the same time:
    // next PC comes from the old (addi) IR, pc_instr takes the old pc.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("seq_pc", pc, 32'h10);
    rs1v = 32'd5;
    rs2v = 32'd5;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hFE000EE3, 32'h0);
    checkOutput("simul_pc",       pc,                  32'h14);
    checkOutput("simul_pc_instr", pc_instr,            32'h10);
    checkOutput("simul_ir",       current_instruction, 32'hFE000EE3);

    // Branch not taken, then taken relative to pc_instr.
    rs2v = 32'd6;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("br_not_taken_pc", pc, 32'h18);
    rs2v = 32'd5;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("br_taken_pc", pc, 32'h0C);

    // Jump beats a taken branch, bit 0 cleared, bit 1 kept.
    checkOutput("jump_taken_pre", {31'b0, branch_taken}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h00000103);
    checkOutput("jump_pc", pc, 32'h00000102);

    // Hold with changing read_data and alu_output.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, i[0], 32'hA5A50000 + i, 32'h00000200 + i);
    checkOutput("hold_pc",       pc,                  32'h00000102);
    checkOutput("hold_ir",       current_instruction, 32'hFE000EE3);
    checkOutput("hold_pc_instr", pc_instr,            32'h10);

    // PC wrap: jump to 0xFFFFFFFC, load a non-branch, then pc+4 wraps to 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFD);
    checkOutput("wrap_setup_pc", pc, 32'hFFFFFFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_pc", pc, 32'h0);

    // Decode table.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, dec_vec[i].insn, 32'h0);
      checkOutput($sformatf("dec%0d_opcode", i), {25'b0, opcode}, {25'b0, dec_vec[i].exp_opcode});
      checkOutput($sformatf("dec%0d_rd", i),     {27'b0, rd},     {27'b0, dec_vec[i].exp_rd});
      checkOutput($sformatf("dec%0d_funct3", i), {29'b0, funct3}, {29'b0, dec_vec[i].exp_funct3});
      checkOutput($sformatf("dec%0d_rs1", i),    {27'b0, rs1},    {27'b0, dec_vec[i].exp_rs1});
      checkOutput($sformatf("dec%0d_rs2", i),    {27'b0, rs2},    {27'b0, dec_vec[i].exp_rs2});
      checkOutput($sformatf("dec%0d_funct7", i), {25'b0, funct7}, {25'b0, dec_vec[i].exp_funct7});
      checkOutput($sformatf("dec%0d_imm", i),    immediate_value, dec_vec[i].exp_imm);
    end

    // Branch condition table.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, br_vec[i].insn, 32'h0);
      rs1v = br_vec[i].a;
      rs2v = br_vec[i].b;
      #1;
      checkOutput($sformatf("br%0d_taken", i), {31'b0, branch_taken}, {31'b0, br_vec[i].exp_taken});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
Front-end of the RV32I multi-cycle processor. It combines the program counter, the instruction register with field decode, and the immediate generator. It latches fetched instruction words from memory and exposes the decoded fields and sign-extended immediate to the control, register-file and ALU datapath. It computes the next PC for sequential, jump and conditional-branch flow.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, instruction-register value on reset (addi x0,x0,0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- read_data  input  32  instruction word from memory read port.
- ir_write  input  1  load read_data into instruction register this edge.
- pc_write  input  1  update PC with next-PC this edge.
- select_pc_value  input  1  1: next PC = jump target from alu_output; 0: sequential/branch path.
- alu_output  input  32  jump target (jal/jalr) from ALU.
- rs1v  input  32  branch compare operand 1.
- rs2v  input  32  branch compare operand 2.
- pc  output  32  current program counter (fetch address).
- pc_instr  output  32  PC of the instruction held in the IR.
- current_instruction  output  32  latched instruction word.
- opcode  output  7  current_instruction[6:0].
- rd  output  5  [11:7].
- funct3  output  3  [14:12].
- rs1  output  5  [19:15].
- rs2  output  5  [24:20].
- funct7  output  7  [31:25].
- immediate_value  output  32  decoded immediate.
- branch_taken  output  1  branch condition result for current instruction.

Behaviour:
- Reset (rst_n=0 at rising edge): pc=RESET_PC, pc_instr=RESET_PC, current_instruction=NOP_INSN. Reset overrides ir_write/pc_write.
- Instruction register: when ir_write=1, current_instruction<=read_data and pc_instr<=pc (the pre-update value). Otherwise both hold.
- Field outputs and immediate_value are combinational from current_instruction. They are valid in the same cycle the IR updates.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111): sext(inst[31:20]).
  - S (0100011): sext({inst[31:25],inst[11:7]}).
  - B (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U (0110111, 0010111): {inst[31:12],12'b0}.
  - J (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - Any other opcode (including R-type 0110011): 32'h0.
- branch_taken (combinational): 0 unless opcode=1100011. For a branch, by funct3:
  - 000 eq; 001 ne.
  - 100 signed lt; 101 signed ge.
  - 110 unsigned lt; 111 unsigned ge.
  - 010/011: not taken.
- Next-PC priority:
  1. select_pc_value=1: alu_output with bit0 forced to 0.
  2. Else if branch_taken: pc_instr + immediate_value.
  3. Else: pc + 4.
- PC updates only when pc_write=1; otherwise it holds.
- All additions are 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0. No alignment trap: misaligned targets other than bit0 pass through.
- Simultaneous ir_write and pc_write:
  - next-PC is computed from pre-edge IR/pc_instr/pc;
  - pc_instr captures the pre-edge pc.
- No internal FSM; sequencing is owned by the external controller.

Test Plan:
- Reset with ir_write=pc_write=1 and read_data=0xFFFFFFFF → pc=0, pc_instr=0, current_instruction=0x00000013, opcode=0010011, immediate_value=0.
- Fetch 0xFFF00093 (addi x1,x0,-1) with ir_write=1, then pc_write=1 → rd=1, rs1=0, funct3=0, immediate_value=0xFFFFFFFF, pc=4, pc_instr=0.
- Immediate formats:
  - 0x00112423 (sw) → imm=8.
  - 0xFE000EE3 (beq, imm=-4) → imm=0xFFFFFFFC.
  - 0x123450B7 (lui) → imm=0x12345000.
  - 0x0080006F (jal, imm=8) → imm=8.
  - 0x002081B3 (add) → imm=0.
- Branch with IR=0xFE000EE3, pc_instr=0x10, pc=0x14:
  - rs1v=rs2v=5, pc_write → pc=0x0C.
  - rs1v=5, rs2v=6 → pc=0x18.
  - blt (funct3=100) with rs1v=0xFFFFFFFF, rs2v=1 → taken.
  - bltu (funct3=110) with the same operands → not taken.
- select_pc_value=1 with alu_output=0x00000103 → pc=0x00000102. Branch_taken is ignored when select_pc_value=1.
- Hold: ir_write=pc_write=0 over several cycles with changing read_data/alu_output → pc and IR unchanged. PC wrap: pc=0xFFFFFFFC, pc_write → pc=0.
